// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder with a one-cycle valid pipeline.
// Ports: clk, rst_n, in_valid/a/b/ci in; s/co/out_valid (+ovf when ADDER_OVF_EN) out.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             out_valid
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic x_y;
        assign x_y      = a[i] ^ b[i];
        assign sum[i]   = x_y ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & x_y);
    end

    // Operands are only sampled when qualified, so X/Z on idle inputs
    // never reaches the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else if (in_valid) begin
            s  <= sum;
            co <= c[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

`ifdef ADDER_OVF_EN
    logic ovf_next;

    // Same-sign operands producing an opposite-sign sum.
    assign ovf_next = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder (WIDTH=4): directed, exhaustive and random.
// Reference model uses plain integer arithmetic.
module tb_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         out_valid;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] m_s = '0;
    logic         m_co = 1'b0;
    logic         m_v = 1'b0;
    logic         m_ov = 1'b0;

    adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .s         (s),
        .co        (co),
        .out_valid (out_valid)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".s"}, 64'(s), 64'(m_s));
        check({tag, ".co"}, 64'(co), 64'(m_co));
        check({tag, ".vld"}, 64'(out_valid), 64'(m_v));
`ifdef ADDER_OVF_EN
        check({tag, ".ovf"}, 64'(ovf), 64'(m_ov));
`endif
    endtask

    task automatic model_reset();
        m_s  = '0;
        m_co = 1'b0;
        m_v  = 1'b0;
        m_ov = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, check 1 later.
    task automatic cyc(input string tag, input logic v, input logic [W-1:0] ai,
                       input logic [W-1:0] bi, input logic cin);
        int t;
        int sa;
        int sb;
        int ss;
        @(negedge clk);
        in_valid = v;
        a        = ai;
        b        = bi;
        ci       = cin;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_v = v;
            if (v) begin
                t    = int'(ai) + int'(bi) + int'(cin);
                m_s  = W'(t % (1 << W));
                m_co = (t >= (1 << W));
                sa   = ai[W-1] ? int'(ai) - (1 << W) : int'(ai);
                sb   = bi[W-1] ? int'(bi) - (1 << W) : int'(bi);
                ss   = sa + sb + int'(cin);
                m_ov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] hold_s;

        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cyc("d3p3", 1'b1, 4'd3, 4'd3, 1'b0);
        cyc("d7p3", 1'b1, 4'd7, 4'd3, 1'b0);
        cyc("d15p1", 1'b1, 4'd15, 4'd1, 1'b0);
        cyc("wrap_ff1", 1'b1, 4'd15, 4'd15, 1'b1);
        cyc("hold", 1'b0, 4'd0, 4'd0, 1'b0);
        cyc("wrap_f01", 1'b1, 4'd15, 4'd0, 1'b1);
        cyc("ovf7p1", 1'b1, 4'd7, 4'd1, 1'b0);
        cyc("ovf8p8", 1'b1, 4'd8, 4'd8, 1'b0);
        cyc("ovf3p3", 1'b1, 4'd3, 4'd3, 1'b0);
        cyc("xidle", 1'b0, 'x, 'x, 1'bx);

        // Inputs change mid-cycle: no combinational path to outputs.
        @(negedge clk);
        hold_s   = s;
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd4;
        #2;
        check("nocomb.s", 64'(s), 64'(hold_s));
        check("nocomb.s_model", 64'(s), 64'(m_s));

        // Async reset mid-stream, away from any clock edge.
        cyc("pre_rst", 1'b1, 4'd3, 4'd3, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        cyc("rst_valid", 1'b1, 4'd5, 4'd5, 1'b0);
        #1;
        rst_n = 1'b1;
        cyc("post_rel", 1'b0, 4'd2, 4'd2, 1'b0);
        cyc("post_rel_v", 1'b1, 4'd2, 4'd2, 1'b1);

        for (int i = 0; i < 512; i++) begin
            cyc("sweep", 1'b1, W'(i >> 5), W'(i >> 1), i[0]);
        end

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            cyc("rand", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
